// File: rtl/tm1638_device_responder.sv
// TM1638 chip-side responder: decodes master commands, holds the 16-byte display RAM
// and shifts out four key-scan bytes on a read, all oversampled by mclk.
module tm1638_device_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic        stb_in,
    input  logic        clk_in,
    input  logic        dio_in,
    output logic        dio_out,
    output logic        dio_oe,
    input  logic [31:0] key_data,
    input  logic [3:0]  disp_raddr,
    output logic [7:0]  disp_rdata,
    output logic        disp_on,
    output logic [2:0]  brightness,
    output logic        frame_done,
    output logic        cmd_err
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        IGNORE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] stb_sync, clk_sync, dio_sync;
    logic                   stb_prev, clk_prev;
    logic                   stb_s, clk_s, dio_s;
    logic                   clk_rise, clk_fall, stb_fall;

    logic [6:0]  sr;
    logic [7:0]  byte_next;
    logic [2:0]  bit_cnt;
    logic [4:0]  bit_idx;
    logic [31:0] tx_reg;
    logic [3:0]  addr;
    logic        rd_mode, fixed_mode, byte_seen;
    logic [7:0]  ram [16];

    logic start_frame, frame_end, shift_en, cmd_done, ram_we;
    logic cmd_data, cmd_ctrl, cmd_addr, cmd_undef;
    logic rd_drive, rd_step, rd_stop;

    // stb syncs reset low so a frame already in progress at reset release is
    // never joined: entering CMD needs a genuine high-to-low transition.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            stb_sync <= '0;
            clk_sync <= '1;
            dio_sync <= '0;
            stb_prev <= 1'b0;
            clk_prev <= 1'b1;
        end else begin
            stb_sync <= {stb_sync[SYNC_STAGES-2:0], stb_in};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], clk_in};
            dio_sync <= {dio_sync[SYNC_STAGES-2:0], dio_in};
            stb_prev <= stb_s;
            clk_prev <= clk_s;
        end
    end

    assign stb_s     = stb_sync[SYNC_STAGES-1];
    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign dio_s     = dio_sync[SYNC_STAGES-1];
    assign clk_rise  = clk_s & ~clk_prev;
    assign clk_fall  = ~clk_s & clk_prev;
    assign stb_fall  = ~stb_s & stb_prev;
    assign byte_next = {dio_s, sr};

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A high stb closes the frame from any state and outranks a coincident clock rise.
    always_comb begin
        state_next = state;
        if (state == IDLE) begin
            if (stb_fall) begin
                state_next = CMD;
            end
        end else if (stb_s) begin
            state_next = IDLE;
        end else begin
            case (state)
                CMD: begin
                    if (clk_rise && bit_cnt == 3'd7) begin
                        case (byte_next[7:6])
                            2'b01:   state_next = byte_next[1] ? RDATA : IGNORE;
                            2'b11:   state_next = WDATA;
                            default: state_next = IGNORE;
                        endcase
                    end
                end
                RDATA: begin
                    if (clk_rise && bit_idx == 5'd31) begin
                        state_next = IGNORE;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        start_frame = 1'b0;
        frame_end   = 1'b0;
        shift_en    = 1'b0;
        cmd_done    = 1'b0;
        ram_we      = 1'b0;
        rd_drive    = 1'b0;
        rd_step     = 1'b0;
        rd_stop     = 1'b0;
        if (state == IDLE) begin
            start_frame = stb_fall;
        end else if (stb_s) begin
            frame_end = 1'b1;
        end else begin
            case (state)
                CMD: begin
                    shift_en = clk_rise;
                    cmd_done = clk_rise && (bit_cnt == 3'd7);
                end
                WDATA: begin
                    shift_en = clk_rise;
                    ram_we   = clk_rise && (bit_cnt == 3'd7);
                end
                RDATA: begin
                    rd_drive = clk_fall;
                    rd_step  = clk_rise;
                    rd_stop  = clk_rise && (bit_idx == 5'd31);
                end
                default: ;
            endcase
        end
        cmd_data  = cmd_done && (byte_next[7:6] == 2'b01);
        cmd_ctrl  = cmd_done && (byte_next[7:6] == 2'b10);
        cmd_addr  = cmd_done && (byte_next[7:6] == 2'b11);
        cmd_undef = cmd_done && (byte_next[7:6] == 2'b00);
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sr         <= '0;
            bit_cnt    <= '0;
            byte_seen  <= 1'b0;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
            rd_mode    <= 1'b0;
            fixed_mode <= 1'b0;
            disp_on    <= 1'b0;
            brightness <= '0;
            addr       <= '0;
        end else begin
            frame_done <= frame_end && byte_seen;
            cmd_err    <= cmd_undef;
            if (start_frame) begin
                bit_cnt   <= '0;
                byte_seen <= 1'b0;
            end else if (shift_en) begin
                sr      <= byte_next[7:1];
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (cmd_done || ram_we) begin
                byte_seen <= 1'b1;
            end
            if (cmd_data) begin
                rd_mode    <= byte_next[1];
                fixed_mode <= byte_next[2];
            end
            if (cmd_ctrl) begin
                disp_on    <= byte_next[3];
                brightness <= byte_next[2:0];
            end
            if (cmd_addr) begin
                addr <= byte_next[3:0];
            end else if (ram_we && !fixed_mode) begin
                addr <= addr + 4'd1;
            end
        end
    end

    // Key bytes are frozen at command decode so the host may change key_data mid-read.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            tx_reg  <= '0;
            bit_idx <= '0;
            dio_oe  <= 1'b0;
            dio_out <= 1'b0;
        end else begin
            if (cmd_data && byte_next[1]) begin
                tx_reg  <= key_data;
                bit_idx <= '0;
            end else if (rd_step) begin
                bit_idx <= bit_idx + 5'd1;
            end
            if (frame_end || rd_stop) begin
                dio_oe  <= 1'b0;
                dio_out <= 1'b0;
            end else if (rd_drive) begin
                dio_oe  <= 1'b1;
                dio_out <= tx_reg[bit_idx];
            end
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                ram[i] <= '0;
            end
        end else if (ram_we) begin
            ram[addr] <= byte_next;
        end
    end

    assign disp_rdata = ram[disp_raddr];

endmodule

// File: tb/tb_tm1638_device_responder.sv
// Bench for tm1638_device_responder: bit-bangs the master side of the link and
// checks display RAM, control outputs and key-scan read data against a local model.
module tb_tm1638_device_responder;

    localparam int HALF = 8;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb_in = 1'b1;
    logic        clk_in = 1'b1;
    logic        dio_in = 1'b0;
    logic        dio_out, dio_oe;
    logic [31:0] key_data = '0;
    logic [3:0]  disp_raddr = '0;
    logic [7:0]  disp_rdata;
    logic        disp_on;
    logic [2:0]  brightness;
    logic        frame_done, cmd_err;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int ce_cnt = 0;

    logic [7:0] exp_ram [16];
    logic [7:0] tx_bytes [32];
    logic [7:0] exp_q [$];
    logic [3:0] m_addr;
    logic       m_fixed = 1'b0;

    tm1638_device_responder #(.SYNC_STAGES(2)) dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .stb_in     (stb_in),
        .clk_in     (clk_in),
        .dio_in     (dio_in),
        .dio_out    (dio_out),
        .dio_oe     (dio_oe),
        .key_data   (key_data),
        .disp_raddr (disp_raddr),
        .disp_rdata (disp_rdata),
        .disp_on    (disp_on),
        .brightness (brightness),
        .frame_done (frame_done),
        .cmd_err    (cmd_err)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (cmd_err === 1'b1) ce_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            clk_in = 1'b0;
            dio_in = b[i];
            cycles(HALF);
            clk_in = 1'b1;
            cycles(HALF);
        end
    endtask

    task automatic frame_begin();
        stb_in = 1'b0;
        cycles(HALF);
    endtask

    task automatic frame_finish();
        cycles(HALF);
        stb_in = 1'b1;
        dio_in = 1'b0;
        cycles(2 * HALF);
    endtask

    task automatic cmd_frame(input logic [7:0] c);
        frame_begin();
        send_byte(c);
        frame_finish();
        if (c[7:6] == 2'b01) m_fixed = c[2];
    endtask

    task automatic write_frame(input logic [7:0] c, input int n);
        frame_begin();
        send_byte(c);
        m_addr = c[3:0];
        for (int i = 0; i < n; i++) begin
            send_byte(tx_bytes[i]);
            exp_ram[m_addr] = tx_bytes[i];
            if (!m_fixed) m_addr = m_addr + 4'd1;
        end
        frame_finish();
    endtask

    task automatic check_ram(input string name);
        for (int i = 0; i < 16; i++) begin
            disp_raddr = 4'(i);
            #1;
            checks++;
            if (disp_rdata !== exp_ram[i]) begin
                errors++;
                $display("[TB] FAIL %s ram[%0d]: got %h expected %h", name, i, disp_rdata, exp_ram[i]);
            end
        end
    endtask

    // Master samples the bit just before raising clk; the device changed it on the previous fall.
    task automatic read_bytes(input int n);
        logic [7:0] got;
        logic [7:0] exp;
        logic       oe_ok;
        for (int b = 0; b < n; b++) begin
            oe_ok = 1'b1;
            for (int i = 0; i < 8; i++) begin
                clk_in = 1'b0;
                cycles(HALF);
                got[i] = dio_out;
                if (dio_oe !== 1'b1) oe_ok = 1'b0;
                clk_in = 1'b1;
                cycles(HALF);
            end
            checks++;
            if (!oe_ok) begin
                errors++;
                $display("[TB] FAIL read_oe byte %0d: dio_oe low while bits expected", b);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL read_data: got %h expected nothing (scoreboard empty)", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("[TB] FAIL read_data: got %h expected %h", got, exp);
                end
            end
        end
    endtask

    task automatic check_oe_low(input string name);
        checks++;
        if (dio_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s: dio_oe got %b expected 0", name, dio_oe);
        end
    endtask

    task automatic read_frame(input logic [31:0] key);
        key_data = key;
        for (int i = 0; i < 4; i++) exp_q.push_back(key[8*i +: 8]);
        frame_begin();
        send_byte(8'h42);
        m_fixed = 1'b0;
        dio_in = 1'b0;
        read_bytes(2);
        key_data = ~key;
        read_bytes(2);
        check_oe_low("read_oe_after_32");
        send_byte(8'hFF);
        check_oe_low("read_oe_extra_clocks");
        frame_finish();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycles(3);
        checks++;
        if ({dio_out, dio_oe, disp_on, brightness, frame_done, cmd_err} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000000",
                     {dio_out, dio_oe, disp_on, brightness, frame_done, cmd_err});
        end
        for (int i = 0; i < 16; i++) exp_ram[i] = 8'h00;
        check_ram("reset");
        rst_n = 1'b1;
        cycles(5);
    endtask

    task automatic test_write_auto();
        int fd0;
        int ce0;
        fd0 = fd_cnt;
        ce0 = ce_cnt;
        cmd_frame(8'h40);
        for (int i = 0; i < 16; i++) tx_bytes[i] = 8'(i);
        write_frame(8'hC0, 16);
        checks++;
        if (fd_cnt - fd0 != 2) begin
            errors++;
            $display("[TB] FAIL write_frame_done: got %0d pulses expected 2", fd_cnt - fd0);
        end
        checks++;
        if (ce_cnt != ce0) begin
            errors++;
            $display("[TB] FAIL write_cmd_err: got %0d pulses expected 0", ce_cnt - ce0);
        end
        check_ram("write_auto");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 17; i++) tx_bytes[i] = 8'(8'h10 + i);
        write_frame(8'hC0, 17);
        check_ram("wrap");
    endtask

    task automatic test_fixed();
        cmd_frame(8'h44);
        tx_bytes[0] = 8'hAA;
        tx_bytes[1] = 8'hBB;
        write_frame(8'hC5, 2);
        check_ram("fixed");
    endtask

    task automatic test_display();
        int ce0;
        cmd_frame(8'h8F);
        checks++;
        if ({disp_on, brightness} !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL disp_8F: got %b expected 1111", {disp_on, brightness});
        end
        cmd_frame(8'h80);
        checks++;
        if ({disp_on, brightness} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL disp_80: got %b expected 0000", {disp_on, brightness});
        end
        cmd_frame(8'h8A);
        ce0 = ce_cnt;
        cmd_frame(8'h00);
        checks++;
        if (ce_cnt - ce0 != 1) begin
            errors++;
            $display("[TB] FAIL cmd_err_pulse: got %0d pulses expected 1", ce_cnt - ce0);
        end
        checks++;
        if ({disp_on, brightness} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL disp_after_undef: got %b expected 1010", {disp_on, brightness});
        end
        check_ram("after_undef");
    endtask

    task automatic test_read();
        read_frame(32'h8765_4321);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL read_leftover: got %0d unread bytes expected 0", exp_q.size());
        end
    endtask

    task automatic test_abort();
        int fd0;
        fd0 = fd_cnt;
        frame_begin();
        send_byte(8'hC3);
        for (int i = 0; i < 5; i++) begin
            clk_in = 1'b0;
            dio_in = 1'b1;
            cycles(HALF);
            clk_in = 1'b1;
            cycles(HALF);
        end
        frame_finish();
        checks++;
        if (fd_cnt - fd0 != 1) begin
            errors++;
            $display("[TB] FAIL abort_frame_done: got %0d pulses expected 1", fd_cnt - fd0);
        end
        check_ram("abort");
    endtask

    task automatic test_reset_midread();
        key_data = 32'hFFFF_FFFF;
        frame_begin();
        send_byte(8'h42);
        dio_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clk_in = 1'b0;
            cycles(HALF);
            clk_in = 1'b1;
            cycles(HALF);
        end
        clk_in = 1'b0;
        cycles(HALF);
        rst_n = 1'b0;
        #1;
        check_oe_low("reset_midread_oe");
        for (int i = 0; i < 16; i++) exp_ram[i] = 8'h00;
        m_fixed = 1'b0;
        check_ram("reset_midread");
        cycles(2);
        rst_n = 1'b1;
        clk_in = 1'b1;
        cycles(HALF);
        send_byte(8'hC0);
        send_byte(8'hFF);
        check_oe_low("post_reset_stb_low_oe");
        frame_finish();
        check_ram("post_reset_ignored");
        tx_bytes[0] = 8'h5A;
        write_frame(8'hC2, 1);
        check_ram("post_reset_write");
        read_frame(32'h0BAD_F00D);
    endtask

    initial begin
        test_reset();
        test_write_auto();
        test_wrap();
        test_fixed();
        test_display();
        test_read();
        test_abort();
        test_reset_midread();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
